// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: control-state codes,
// opcode values and the smallest watchdog limit that still fits the
// longest instruction (ADD/SUB reach NEXT at step 6).
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH_PC   = 4'd1,
        S_FETCH_INST = 4'd2,
        S_HALT       = 4'd3,
        S_JUMP       = 4'd4,
        S_OUT_A      = 4'd5,
        S_LOAD_ADDR  = 4'd6,
        S_RAM_A      = 4'd7,
        S_RAM_B      = 4'd8,
        S_ALU_OP     = 4'd9,
        S_STORE_A    = 4'd10,
        S_NEXT       = 4'd11
    } state_t;

    localparam int OP_NOP = 'h00;
    localparam int OP_LDA = 'h01;
    localparam int OP_ADD = 'h02;
    localparam int OP_SUB = 'h03;
    localparam int OP_STA = 'h04;
    localparam int OP_OUT = 'h05;
    localparam int OP_JMP = 'h06;
    localparam int OP_JEZ = 'h07;
    localparam int OP_JNZ = 'h08;
    localparam int OP_HLT = 'h09;

    localparam int MIN_MAX_CYCLES = 7;

endpackage

// File: rtl/cpu_seq_table.sv
// Combinational step table: given the step being left, the opcode and the
// zero flag, returns the control state of the following step.
// Ports: i_cycle (current step), i_opcode, i_zero_flag -> o_next_state, o_legal.
module cpu_seq_table
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int CYCLE_W  = 4
) (
    input  logic [CYCLE_W-1:0]  i_cycle,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_zero_flag,
    output state_t              o_next_state,
    output logic                o_legal
);

    localparam logic [CYCLE_W-1:0] C1 = CYCLE_W'(1);
    localparam logic [CYCLE_W-1:0] C2 = CYCLE_W'(2);
    localparam logic [CYCLE_W-1:0] C3 = CYCLE_W'(3);
    localparam logic [CYCLE_W-1:0] C4 = CYCLE_W'(4);

    always_comb begin
        o_next_state = S_NEXT;
        o_legal      = 1'b1;
        case (i_opcode)
            OPCODE_W'(OP_NOP): o_next_state = S_NEXT;
            OPCODE_W'(OP_OUT): o_next_state = (i_cycle == C1) ? S_OUT_A : S_NEXT;
            OPCODE_W'(OP_HLT): o_next_state = (i_cycle == C1) ? S_HALT  : S_NEXT;
            OPCODE_W'(OP_JMP): begin
                case (i_cycle)
                    C1:      o_next_state = S_FETCH_PC;
                    C2:      o_next_state = S_JUMP;
                    default: o_next_state = S_NEXT;
                endcase
            end
            // Conditional jumps resolve on the step-2 -> step-3 transition only.
            OPCODE_W'(OP_JEZ), OPCODE_W'(OP_JNZ): begin
                case (i_cycle)
                    C1: o_next_state = S_FETCH_PC;
                    C2: begin
                        if (i_zero_flag == (i_opcode == OPCODE_W'(OP_JEZ)))
                            o_next_state = S_JUMP;
                        else
                            o_next_state = S_NEXT;
                    end
                    default: o_next_state = S_NEXT;
                endcase
            end
            OPCODE_W'(OP_LDA), OPCODE_W'(OP_STA): begin
                case (i_cycle)
                    C1: o_next_state = S_FETCH_PC;
                    C2: o_next_state = S_LOAD_ADDR;
                    C3: o_next_state = (i_opcode == OPCODE_W'(OP_LDA)) ? S_RAM_A : S_STORE_A;
                    default: o_next_state = S_NEXT;
                endcase
            end
            OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
                case (i_cycle)
                    C1:      o_next_state = S_FETCH_PC;
                    C2:      o_next_state = S_LOAD_ADDR;
                    C3:      o_next_state = S_RAM_B;
                    C4:      o_next_state = S_ALU_OP;
                    default: o_next_state = S_NEXT;
                endcase
            end
            default: begin
                o_legal      = 1'b0;
                o_next_state = S_NEXT;
            end
        endcase
        // Step 1 is common to every instruction.
        if (i_cycle == '0)
            o_next_state = S_FETCH_INST;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: walks each opcode through its control steps, one per clock.
// Ports: clk, reset (sync, active high), opcode, zero_flag, stall, resume ->
// state, cycle, instr_done, seq_error (sticky). stall freezes all state.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W   = 8,
    parameter int CYCLE_W    = 4,
    parameter int MAX_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                stall,
    input  logic                resume,
    output logic [3:0]          state,
    output logic [CYCLE_W-1:0]  cycle,
    output logic                instr_done,
    output logic                seq_error
);

    if (MAX_CYCLES < MIN_MAX_CYCLES) begin : g_bad_max_cycles
        $error("cpu_sequencer: MAX_CYCLES must be at least %0d", MIN_MAX_CYCLES);
    end
    if ((MAX_CYCLES - 1) >= (2 ** CYCLE_W)) begin : g_bad_cycle_w
        $error("cpu_sequencer: CYCLE_W too narrow for MAX_CYCLES");
    end

    localparam logic [CYCLE_W-1:0] LP_WD_LIMIT = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] LP_DECODE   = CYCLE_W'(1);

    state_t              r_state;
    logic [CYCLE_W-1:0]  r_cycle;
    logic [OPCODE_W-1:0] r_opcode;
    logic                r_error;

    logic [OPCODE_W-1:0] w_opcode;
    state_t              w_next_state;
    logic                w_legal;

    // The decode edge looks at the live opcode; every later step uses the copy
    // captured on that edge so the instruction register may change underneath.
    assign w_opcode = (r_cycle == LP_DECODE) ? opcode : r_opcode;

    cpu_seq_table #(
        .OPCODE_W (OPCODE_W),
        .CYCLE_W  (CYCLE_W)
    ) u_table (
        .i_cycle      (r_cycle),
        .i_opcode     (w_opcode),
        .i_zero_flag  (zero_flag),
        .o_next_state (w_next_state),
        .o_legal      (w_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH_PC;
            r_cycle  <= '0;
            r_opcode <= '0;
            r_error  <= 1'b0;
        end else if (!stall) begin
            if (r_state == S_NEXT) begin
                r_state <= S_FETCH_PC;
                r_cycle <= '0;
            end else if (r_state == S_HALT) begin
                if (resume) begin
                    r_state <= S_NEXT;
                    r_cycle <= r_cycle + CYCLE_W'(1);
                end
            end else if (r_cycle == LP_WD_LIMIT) begin
                // Watchdog: abandon the instruction and restart the fetch.
                r_state <= S_FETCH_PC;
                r_cycle <= '0;
                r_error <= 1'b1;
            end else begin
                r_state <= w_next_state;
                r_cycle <= r_cycle + CYCLE_W'(1);
                if (r_cycle == LP_DECODE) begin
                    r_opcode <= opcode;
                    if (!w_legal)
                        r_error <= 1'b1;
                end
            end
        end
    end

    assign state      = r_state;
    assign cycle      = r_cycle;
    assign instr_done = (r_state == S_NEXT);
    assign seq_error  = r_error;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 8, opcode width in bits.
REQ-002 Parameter CYCLE_W, default 4, width of the cycle counter.
REQ-003 Parameter MAX_CYCLES, default 8, watchdog limit on steps per instruction; values below 7 SHALL fail elaboration.
REQ-004 Port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit, synchronous active-high reset.
REQ-006 Port opcode, input, OPCODE_W bits, instruction register contents.
REQ-007 Port zero_flag, input, 1 bit, ALU zero flag for conditional jumps.
REQ-008 Port stall, input, 1 bit, freezes the sequencer.
REQ-009 Port resume, input, 1 bit, leaves HALT.
REQ-010 Port state, output, 4 bits, registered control state.
REQ-011 Port cycle, output, CYCLE_W bits, registered step index of the current state.
REQ-012 Port instr_done, output, 1 bit, high while state==NEXT.
REQ-013 Port seq_error, output, 1 bit, sticky flag for an illegal opcode or a watchdog trip.

Function
REQ-014 State codes: FETCH_PC=1, FETCH_INST=2, HALT=3, JUMP=4, OUT_A=5, LOAD_ADDR=6, RAM_A=7, RAM_B=8, ALU_OP=9, STORE_A=10, NEXT=11.
REQ-015 Opcodes: NOP=0x00, LDA=0x01, ADD=0x02, SUB=0x03, STA=0x04, OUT=0x05, JMP=0x06, JEZ=0x07, JNZ=0x08, HLT=0x09; all other values are illegal.
REQ-016 Every instruction SHALL begin with cycle 0 = FETCH_PC and cycle 1 = FETCH_INST.
REQ-017 Sequences from cycle 2:
 - NOP: NEXT.
 - OUT: OUT_A, NEXT.
 - HLT: HALT.
 - JMP: FETCH_PC, JUMP, NEXT.
 - JEZ/JNZ: FETCH_PC, then JUMP if the condition holds, else NEXT; after JUMP, NEXT.
 - LDA: FETCH_PC, LOAD_ADDR, RAM_A, NEXT.
 - STA: FETCH_PC, LOAD_ADDR, STORE_A, NEXT.
 - ADD/SUB: FETCH_PC, LOAD_ADDR, RAM_B, ALU_OP, NEXT.
REQ-018 On the edge that moves to cycle 2, the block SHALL decode from the live opcode and latch it internally; later steps SHALL use the latched value only.
REQ-019 The JEZ (zero_flag=1) and JNZ (zero_flag=0) conditions SHALL be sampled on the edge that moves to cycle 3.
REQ-020 After any NEXT, the next unstalled edge SHALL load state=FETCH_PC, cycle=0; there is no padding to a fixed length.
REQ-021 While stall=1 the state and cycle outputs SHALL hold, and zero_flag and opcode are not sampled.
REQ-022 HALT SHALL hold until resume=1 with stall=0, then advance to NEXT at cycle+1; resume outside HALT SHALL be ignored.
REQ-023 An illegal opcode SHALL produce NEXT at cycle 2 and set seq_error.
REQ-024 If cycle reaches MAX_CYCLES-1 in any state other than NEXT or HALT, the next edge SHALL force FETCH_PC/cycle 0 and set seq_error.
REQ-025 instr_done SHALL be decoded from the state register, with no combinational path from the inputs.

Reset
REQ-026 Reset SHALL take priority over stall and resume.
REQ-027 Reset SHALL apply state=FETCH_PC, cycle=0, seq_error=0, instr_done=0 and clear the latched opcode, including mid-instruction and while in HALT.

Structure
REQ-028 The state codes, opcodes and the minimum MAX_CYCLES value SHALL live in the shared package cpu_pkg.
REQ-029 The combinational step table SHALL be the sub-module cpu_seq_table: inputs (cycle, opcode, zero_flag), outputs (next state, legal).

Verification
REQ-030 Reset, then opcode=0x02, stall=0 -> states 1,2,1,6,8,9,11 with cycles 0..6, then 1/0.
REQ-031 Opcode=0x07 with zero_flag=0 at the cycle-3 edge -> states 1,2,1,11; with zero_flag=1 -> 1,2,1,4,11.
REQ-032 Opcode=0x09 -> HALT held 10 clocks; resume pulse -> NEXT at cycle 3, then FETCH_PC at cycle 0.
REQ-033 Opcode=0x3F -> NEXT at cycle 2, seq_error=1 held through the next instructions until reset.
REQ-034 Opcode=0x01 with stall=1 for 3 clocks at cycle 3 -> LOAD_ADDR/3 held 3 clocks, then RAM_A/4.
REQ-035 Reset asserted at cycle 4 of an ADD -> FETCH_PC/0 on the next edge, seq_error=0.
